hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core. Consumes the load-use request from the forwarding unit, branch redirects from EX, and busy flags from the instruction/data memory ports, and drives per-stage register enables and flushes. Owns the one-entry lock register that saves a write-back value across a load-use stall. Drives `lock_forward_signal`, `lock_forward_rs` and `lock_forward_data` back to the forwarding unit and EX operand muxes (forward select 3). Also keeps saturating stall and flush performance counters.

---
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes, the one-entry load-use
// lock register feeding EX forward select 3, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_stall_flush,
  input  logic             load_use_wb_lock_signal,
  input  logic             load_use_rs_lock_num,
  input  logic [XLEN-1:0]  WB_rd_data,
  input  logic             EX_branch_taken,
  input  logic             IM_stall,
  input  logic             DM_stall,
  output logic             PC_en,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             lock_forward_signal,
  output logic             lock_forward_rs,
  output logic [XLEN-1:0]  lock_forward_data,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, REPLAY} state_t;

  state_t state, state_next;
  logic   mem_stall;
  logic   lu;
  logic   branch_flush;
  logic   release_lock;

  always_comb begin
    mem_stall    = IM_stall | DM_stall;
    lu           = load_use_stall_flush & ~mem_stall;
    branch_flush = EX_branch_taken & ~mem_stall & ~lu;
    release_lock = (state == REPLAY) & ~mem_stall & ~lu;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Priority is mem_stall > load-use > branch; a load-use hides any branch
  // because the EX operands are not valid yet.
  always_comb begin
    state_next   = state;
    PC_en        = 1'b1;
    IF_ID_en     = 1'b1;
    ID_EX_en     = 1'b1;
    EX_MEM_en    = 1'b1;
    MEM_WB_en    = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    if (mem_stall) begin
      PC_en     = 1'b0;
      IF_ID_en  = 1'b0;
      ID_EX_en  = 1'b0;
      EX_MEM_en = 1'b0;
      MEM_WB_en = 1'b0;
    end else if (lu) begin
      PC_en        = 1'b0;
      IF_ID_en     = 1'b0;
      ID_EX_en     = 1'b0;
      EX_MEM_flush = 1'b1;
      state_next   = REPLAY;
    end else begin
      if (branch_flush) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end
      state_next = RUN;
    end
  end

  // lock_forward_signal doubles as lock_valid: it is only ever set together
  // with the move into REPLAY and cleared when REPLAY retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_forward_signal <= 1'b0;
      lock_forward_rs     <= 1'b0;
      lock_forward_data   <= '0;
    end else if (lu) begin
      lock_forward_signal <= load_use_wb_lock_signal;
      if (load_use_wb_lock_signal) begin
        lock_forward_rs   <= load_use_rs_lock_num;
        lock_forward_data <= WB_rd_data;
      end
    end else if (release_lock) begin
      lock_forward_signal <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!PC_en && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (branch_flush && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second CNT_W=4 instance
// shares the stimulus so counter saturation can be reached quickly.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_use_stall_flush = 1'b0;
  logic        load_use_wb_lock_signal = 1'b0;
  logic        load_use_rs_lock_num = 1'b0;
  logic [31:0] WB_rd_data = '0;
  logic        EX_branch_taken = 1'b0;
  logic        IM_stall = 1'b0;
  logic        DM_stall = 1'b0;

  logic        PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic        IF_ID_flush, ID_EX_flush, EX_MEM_flush;
  logic        lock_forward_signal, lock_forward_rs;
  logic [31:0] lock_forward_data, stall_cycles, flush_count;

  logic        s_PC_en, s_IF_ID_en, s_ID_EX_en, s_EX_MEM_en, s_MEM_WB_en;
  logic        s_IF_ID_flush, s_ID_EX_flush, s_EX_MEM_flush;
  logic        s_lock_forward_signal, s_lock_forward_rs;
  logic [31:0] s_lock_forward_data;
  logic [3:0]  s_stall_cycles, s_flush_count;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [4:0] en;
  logic [2:0] fl;
  assign en = {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en};
  assign fl = {IF_ID_flush, ID_EX_flush, EX_MEM_flush};

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_stall_flush(load_use_stall_flush),
    .load_use_wb_lock_signal(load_use_wb_lock_signal),
    .load_use_rs_lock_num(load_use_rs_lock_num),
    .WB_rd_data(WB_rd_data), .EX_branch_taken(EX_branch_taken),
    .IM_stall(IM_stall), .DM_stall(DM_stall),
    .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en),
    .EX_MEM_en(EX_MEM_en), .MEM_WB_en(MEM_WB_en),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
    .lock_forward_signal(lock_forward_signal), .lock_forward_rs(lock_forward_rs),
    .lock_forward_data(lock_forward_data),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_ctrl #(.XLEN(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .load_use_stall_flush(load_use_stall_flush),
    .load_use_wb_lock_signal(load_use_wb_lock_signal),
    .load_use_rs_lock_num(load_use_rs_lock_num),
    .WB_rd_data(WB_rd_data), .EX_branch_taken(EX_branch_taken),
    .IM_stall(IM_stall), .DM_stall(DM_stall),
    .PC_en(s_PC_en), .IF_ID_en(s_IF_ID_en), .ID_EX_en(s_ID_EX_en),
    .EX_MEM_en(s_EX_MEM_en), .MEM_WB_en(s_MEM_WB_en),
    .IF_ID_flush(s_IF_ID_flush), .ID_EX_flush(s_ID_EX_flush), .EX_MEM_flush(s_EX_MEM_flush),
    .lock_forward_signal(s_lock_forward_signal), .lock_forward_rs(s_lock_forward_rs),
    .lock_forward_data(s_lock_forward_data),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  // Leaves the bench 1 time unit after a rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_use_stall_flush = 1'b0;
    load_use_wb_lock_signal = 1'b0;
    load_use_rs_lock_num = 1'b0;
    WB_rd_data = '0;
    EX_branch_taken = 1'b0;
    IM_stall = 1'b0;
    DM_stall = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive_lu(input logic lock, input logic rs, input logic [31:0] data);
    load_use_stall_flush = 1'b1;
    load_use_wb_lock_signal = lock;
    load_use_rs_lock_num = rs;
    WB_rd_data = data;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    n_compared++;
    if (lock_forward_signal !== 1'b0) begin n_mismatched++;
      $display("[TB] FAIL reset_lock_sig: got %b want 0", lock_forward_signal); end
    n_compared++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin n_mismatched++;
      $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count); end
    n_compared++;
    if (lock_forward_data !== 32'd0) begin n_mismatched++;
      $display("[TB] FAIL reset_lock_data: got %h want 0", lock_forward_data); end
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    n_compared++;
    if (en !== 5'b11111 || fl !== 3'b000) begin n_mismatched++;
      $display("[TB] FAIL idle_en_fl: got %b/%b want 11111/000", en, fl); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_lu(1'b1, 1'b1, 32'hDEADBEEF);
    #1;
    n_compared++;
    if (en !== 5'b00011 || fl !== 3'b001) begin n_mismatched++;
      $display("[TB] FAIL lu_en_fl: got %b/%b want 00011/001", en, fl); end
    tick();
    clear_inputs();
    #1;
    n_compared++;
    if (lock_forward_signal !== 1'b1 || lock_forward_rs !== 1'b1 || lock_forward_data !== 32'hDEADBEEF) begin
      n_mismatched++;
      $display("[TB] FAIL lu_lock_out: got %b %b %h want 1 1 deadbeef",
               lock_forward_signal, lock_forward_rs, lock_forward_data); end
    n_compared++;
    if (en !== 5'b11111 || fl !== 3'b000) begin n_mismatched++;
      $display("[TB] FAIL replay_en_fl: got %b/%b want 11111/000", en, fl); end
    tick();
    n_compared++;
    if (lock_forward_signal !== 1'b0) begin n_mismatched++;
      $display("[TB] FAIL lu_release: got %b want 0", lock_forward_signal); end
    n_compared++;
    if (stall_cycles !== 32'd1) begin n_mismatched++;
      $display("[TB] FAIL lu_stall_cnt: got %0d want 1", stall_cycles); end
  endtask

  task automatic test_replay_mem_stall();
    do_reset();
    drive_lu(1'b1, 1'b0, 32'hCAFE0001);
    tick();
    clear_inputs();
    DM_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_compared++;
      if (en !== 5'b00000 || fl !== 3'b000) begin n_mismatched++;
        $display("[TB] FAIL stall_en_fl[%0d]: got %b/%b want 00000/000", i, en, fl); end
      n_compared++;
      if (lock_forward_signal !== 1'b1 || lock_forward_data !== 32'hCAFE0001) begin n_mismatched++;
        $display("[TB] FAIL stall_lock_hold[%0d]: got %b %h want 1 cafe0001", i,
                 lock_forward_signal, lock_forward_data); end
      tick();
    end
    DM_stall = 1'b0;
    #1;
    n_compared++;
    if (lock_forward_signal !== 1'b1 || en !== 5'b11111) begin n_mismatched++;
      $display("[TB] FAIL replay_after_stall: got sig %b en %b want 1 11111", lock_forward_signal, en); end
    tick();
    n_compared++;
    if (lock_forward_signal !== 1'b0) begin n_mismatched++;
      $display("[TB] FAIL stall_release: got %b want 0", lock_forward_signal); end
    n_compared++;
    if (stall_cycles !== 32'd4) begin n_mismatched++;
      $display("[TB] FAIL stall_cnt4: got %0d want 4", stall_cycles); end
  endtask

  task automatic test_branch();
    do_reset();
    drive_lu(1'b0, 1'b0, 32'h0);
    EX_branch_taken = 1'b1;
    #1;
    n_compared++;
    if (fl !== 3'b001 || en !== 5'b00011) begin n_mismatched++;
      $display("[TB] FAIL br_under_lu: got %b/%b want 00011/001", en, fl); end
    tick();
    load_use_stall_flush = 1'b0;
    #1;
    n_compared++;
    if (flush_count !== 32'd0 || lock_forward_signal !== 1'b0) begin n_mismatched++;
      $display("[TB] FAIL br_ignored: got cnt %0d sig %b want 0 0", flush_count, lock_forward_signal); end
    n_compared++;
    if (fl !== 3'b110 || en !== 5'b11111) begin n_mismatched++;
      $display("[TB] FAIL br_replay_fl: got %b/%b want 11111/110", en, fl); end
    tick();
    n_compared++;
    if (flush_count !== 32'd1) begin n_mismatched++;
      $display("[TB] FAIL br_cnt1: got %0d want 1", flush_count); end
    tick();
    n_compared++;
    if (flush_count !== 32'd2) begin n_mismatched++;
      $display("[TB] FAIL br_cnt2: got %0d want 2", flush_count); end
    EX_branch_taken = 1'b0;
  endtask

  task automatic test_lu_under_im_stall();
    do_reset();
    IM_stall = 1'b1;
    drive_lu(1'b1, 1'b1, 32'hBAD0BAD0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_compared++;
      if (en !== 5'b00000 || fl !== 3'b000) begin n_mismatched++;
        $display("[TB] FAIL im_en_fl[%0d]: got %b/%b want 00000/000", i, en, fl); end
      tick();
      n_compared++;
      if (lock_forward_signal !== 1'b0) begin n_mismatched++;
        $display("[TB] FAIL im_no_capture[%0d]: got %b want 0", i, lock_forward_signal); end
    end
    IM_stall = 1'b0;
    drive_lu(1'b1, 1'b0, 32'h12345678);
    #1;
    n_compared++;
    if (en !== 5'b00011 || fl !== 3'b001) begin n_mismatched++;
      $display("[TB] FAIL im_lu_fire: got %b/%b want 00011/001", en, fl); end
    tick();
    clear_inputs();
    n_compared++;
    if (lock_forward_signal !== 1'b1 || lock_forward_rs !== 1'b0 || lock_forward_data !== 32'h12345678) begin
      n_mismatched++;
      $display("[TB] FAIL im_capture: got %b %b %h want 1 0 12345678",
               lock_forward_signal, lock_forward_rs, lock_forward_data); end
    tick();
    n_compared++;
    if (lock_forward_signal !== 1'b0 || stall_cycles !== 32'd3) begin n_mismatched++;
      $display("[TB] FAIL im_end: got sig %b cnt %0d want 0 3", lock_forward_signal, stall_cycles); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_lu(1'b1, 1'b1, 32'hAAAA5555);
    tick();
    drive_lu(1'b1, 1'b0, 32'h0F0F0F0F);
    #1;
    n_compared++;
    if (en !== 5'b00011 || fl !== 3'b001) begin n_mismatched++;
      $display("[TB] FAIL b2b_en_fl: got %b/%b want 00011/001", en, fl); end
    tick();
    clear_inputs();
    n_compared++;
    if (lock_forward_signal !== 1'b1 || lock_forward_rs !== 1'b0 || lock_forward_data !== 32'h0F0F0F0F) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_recapture: got %b %b %h want 1 0 0f0f0f0f",
               lock_forward_signal, lock_forward_rs, lock_forward_data); end
    tick();
    n_compared++;
    if (lock_forward_signal !== 1'b0 || stall_cycles !== 32'd2) begin n_mismatched++;
      $display("[TB] FAIL b2b_end: got sig %b cnt %0d want 0 2", lock_forward_signal, stall_cycles); end
  endtask

  task automatic test_saturation();
    do_reset();
    DM_stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    DM_stall = 1'b0;
    n_compared++;
    if (s_stall_cycles !== 4'd15) begin n_mismatched++;
      $display("[TB] FAIL sat_stall: got %0d want 15", s_stall_cycles); end
    n_compared++;
    if (stall_cycles !== 32'd20) begin n_mismatched++;
      $display("[TB] FAIL wide_stall: got %0d want 20", stall_cycles); end
    EX_branch_taken = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    EX_branch_taken = 1'b0;
    n_compared++;
    if (s_flush_count !== 4'd15 || flush_count !== 32'd20) begin n_mismatched++;
      $display("[TB] FAIL sat_flush: got %0d/%0d want 15/20", s_flush_count, flush_count); end
  endtask

  task automatic test_reset_mid_replay();
    do_reset();
    drive_lu(1'b1, 1'b1, 32'h13579BDF);
    tick();
    clear_inputs();
    n_compared++;
    if (lock_forward_signal !== 1'b1) begin n_mismatched++;
      $display("[TB] FAIL pre_reset_lock: got %b want 1", lock_forward_signal); end
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (lock_forward_signal !== 1'b0 || lock_forward_data !== 32'd0 || lock_forward_rs !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset_lock: got %b %b %h want 0 0 0",
               lock_forward_signal, lock_forward_rs, lock_forward_data); end
    rst_n = 1'b1;
    tick();
    n_compared++;
    if (lock_forward_signal !== 1'b0 || en !== 5'b11111) begin n_mismatched++;
      $display("[TB] FAIL post_reset: got sig %b en %b want 0 11111", lock_forward_signal, en); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_replay_mem_stall();
    test_branch();
    test_lu_under_im_stall();
    test_back_to_back();
    test_saturation();
    test_reset_mid_replay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
